// File: rtl/spi_fpga_regif_if.sv
// Bundle of the SPI pins and the internal register bus seen by spi_fpga_regif.
// The slave modport is the register-interface block's view; master is the
// view of whatever drives the SPI pins and serves the register bus.
interface spi_fpga_regif_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              spi_sck;
    logic              fpga_cs;
    logic              fpga_mosi;
    logic              fpga_miso;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wdata;
    logic              reg_wr;
    logic              reg_rd;
    logic [DATA_W-1:0] reg_rdata;
    logic              busy;
    logic              frame_err;

    modport slave (
        input  spi_sck,
        input  fpga_cs,
        input  fpga_mosi,
        output fpga_miso,
        output reg_addr,
        output reg_wdata,
        output reg_wr,
        output reg_rd,
        input  reg_rdata,
        output busy,
        output frame_err
    );

    modport master (
        output spi_sck,
        output fpga_cs,
        output fpga_mosi,
        input  fpga_miso,
        input  reg_addr,
        input  reg_wdata,
        input  reg_wr,
        input  reg_rd,
        output reg_rdata,
        input  busy,
        input  frame_err
    );
endinterface

// File: rtl/spi_fpga_regif.sv
// SPI mode-0 slave on the FPGA leg of the board SPI mux. SCK/CS/MOSI are
// oversampled in the system clock domain and fixed-length frames
// {R/W, address, data} are turned into one-clock register strobes.
module spi_fpga_regif #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    spi_fpga_regif_if.slave bus
);
    localparam int FL = 1 + ADDR_W + DATA_W;
    localparam int CW = $clog2(FL + 1);
    // Shift register only needs to hold the longer of command and data field
    localparam int SW = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
    localparam logic [CW-1:0] CMD_LEN = CW'(ADDR_W + 1);
    localparam logic [CW-1:0] FL_LEN  = CW'(FL);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sck_dly_q, cs_dly_q;
    logic                   sck_s, cs_s, mosi_s;
    logic                   sck_rise, sck_fall, cs_rise, cs_fall;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [SW-1:0]     shreg_q, shreg_d, sh_next;
    logic              rw_q, rw_d;
    logic              rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic              miso_q, miso_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;
    logic              err_q, err_d;

    // Synchronise the SPI pins and keep one extra delayed copy for edge detect.
    // CS resets to 0 so a CS already low at reset release never looks like a
    // falling edge: the host must raise and lower it again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sck_dly_q   <= 1'b0;
            cs_dly_q    <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], bus.spi_sck};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.fpga_cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.fpga_mosi};
            sck_dly_q   <= sck_sync_q[SYNC_STAGES-1];
            cs_dly_q    <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_dly_q;
    assign sck_fall = ~sck_s & sck_dly_q;
    assign cs_rise  = cs_s & ~cs_dly_q;
    assign cs_fall  = ~cs_s & cs_dly_q;

    // Frame state machine: bit counting, strobes and MISO shifting
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        rw_d      = rw_q;
        rd_pend_d = 1'b0;
        tx_d      = tx_q;
        miso_d    = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        err_d     = 1'b0;
        cnt_inc   = cnt_q + CW'(1);
        sh_next   = (shreg_q << 1) | SW'(mosi_s);

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    cnt_d   = '0;
                    shreg_d = '0;
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (sck_rise) begin
                    shreg_d = sh_next;
                    cnt_d   = cnt_inc;
                    if (cnt_inc == CMD_LEN) begin
                        addr_d    = sh_next[ADDR_W-1:0];
                        rw_d      = sh_next[ADDR_W];
                        rd_d      = sh_next[ADDR_W];
                        rd_pend_d = sh_next[ADDR_W];
                        state_d   = ST_DATA;
                    end
                end
                // The edge above is counted first; a command phase can never
                // complete a frame, so CS high here always aborts.
                if (cs_rise) begin
                    rd_pend_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (rw_q) begin
                    miso_d = miso_q;
                    if (rd_pend_q) begin
                        tx_d   = bus.reg_rdata;
                        miso_d = bus.reg_rdata[DATA_W-1];
                    end else if (sck_fall && cnt_q != CMD_LEN) begin
                        // The fall right after the last command bit keeps
                        // the MSB on the line for the first data rise.
                        tx_d   = tx_q << 1;
                        miso_d = tx_q[DATA_W-2];
                    end
                end
                if (sck_rise) begin
                    shreg_d = sh_next;
                    cnt_d   = cnt_inc;
                    if (cnt_inc == FL_LEN) begin
                        miso_d  = 1'b0;
                        state_d = ST_DONE;
                        if (!rw_q) begin
                            wr_d    = 1'b1;
                            wdata_d = sh_next[DATA_W-1:0];
                        end
                    end
                end
                if (cs_rise && !(sck_rise && cnt_inc == FL_LEN)) begin
                    wr_d    = 1'b0;
                    err_d   = 1'b1;
                    miso_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (cs_s) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            rw_q      <= 1'b0;
            rd_pend_q <= 1'b0;
            tx_q      <= '0;
            miso_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            rw_q      <= rw_d;
            rd_pend_q <= rd_pend_d;
            tx_q      <= tx_d;
            miso_q    <= miso_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            err_q     <= err_d;
        end
    end

    assign bus.fpga_miso = miso_q;
    assign bus.reg_addr  = addr_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.reg_wr    = wr_q;
    assign bus.reg_rd    = rd_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.frame_err = err_q;
endmodule

// File: tb/tb_spi_fpga_regif.sv
// Bench for spi_fpga_regif: a bit-banged SPI host, a register file that
// serves reads only while reg_rd is high, and a frame-level model.
module tb_spi_fpga_regif;
    logic clk;
    logic rst;

    spi_fpga_regif_if #(.ADDR_W(7), .DATA_W(8)) bus();

    spi_fpga_regif #(.ADDR_W(7), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Register file behind the bus (updated by the DUT) and the model copy
    logic [7:0] tb_regs   [128];
    logic [7:0] model_mem [128];
    logic [7:0] junk;

    always @(posedge clk) begin
        junk <= 8'($urandom);
        if (bus.reg_wr) tb_regs[bus.reg_addr] <= bus.reg_wdata;
    end
    assign bus.reg_rdata = bus.reg_rd ? tb_regs[bus.reg_addr] : junk;

    // Strobe monitor
    int wr_n = 0, rd_n = 0, err_n = 0, busy_n = 0, busy_base = 0;
    logic [6:0] last_wa, last_ra;
    logic [7:0] last_wd;
    always @(negedge clk) begin
        if (bus.reg_wr) begin wr_n++; last_wa = bus.reg_addr; last_wd = bus.reg_wdata; end
        if (bus.reg_rd) begin rd_n++; last_ra = bus.reg_addr; end
        if (bus.frame_err) err_n++;
        if (bus.busy) busy_n++;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Host side of one frame: n SCK rises, half-period hp clocks, CS gap after.
    task automatic spi_xfer(input logic [15:0] frame, input int n, input int hp,
                            input bit simul, input int rst_at, input int gap,
                            output logic [7:0] mbits, output int mcnt);
        mbits = '0;
        mcnt  = 0;
        bus.fpga_cs = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.fpga_mosi = (i < 16) ? frame[15-i] : 1'($urandom);
            tick(hp);
            if (i >= 8 && i < 16) begin
                mbits = {mbits[6:0], bus.fpga_miso};
                mcnt++;
            end
            bus.spi_sck = 1'b1;
            if (simul && i == n - 1) bus.fpga_cs = 1'b1;
            if (rst_at == i + 1) begin
                rst = 1'b1;
                #1;
                chk("rst_outputs", {bus.busy, bus.reg_wr, bus.reg_rd, bus.frame_err,
                                    bus.fpga_miso, bus.reg_addr, bus.reg_wdata}, 32'd0);
                tick(3);
                rst = 1'b0;
                busy_base = busy_n;
            end
            tick(hp);
            bus.spi_sck = 1'b0;
        end
        tick(hp);
        bus.fpga_cs = 1'b1;
        tick(gap);
    endtask

    // One frame checked against the frame-level rules
    task automatic run_frame(input bit rw, input logic [6:0] addr, input logic [7:0] data,
                             input int n, input int hp, input bit simul, input int gap);
        int wr0, rd0, err0, mcnt;
        logic [7:0] mbits, exp_rd;
        bit full, cmd;
        wr0 = wr_n; rd0 = rd_n; err0 = err_n;
        exp_rd = model_mem[addr];
        full = (n >= 16);
        cmd  = (n >= 8);
        spi_xfer({rw, addr, data}, n, hp, simul, 0, gap, mbits, mcnt);
        chk("wr_count", wr_n - wr0, (full && !rw) ? 1 : 0);
        chk("rd_count", rd_n - rd0, (cmd && rw) ? 1 : 0);
        chk("err_count", err_n - err0, full ? 0 : 1);
        if (full && !rw) begin
            chk("wr_addr", last_wa, addr);
            chk("wr_data", last_wd, data);
            model_mem[addr] = data;
        end
        if (cmd && rw) chk("rd_addr", last_ra, addr);
        if (rw && mcnt > 0) chk("miso_bits", mbits, exp_rd >> (8 - mcnt));
        chk("idle_busy", bus.busy, 1'b0);
        chk("idle_miso", bus.fpga_miso, 1'b0);
        $display("frame rw=%0d addr=0x%02h data=0x%02h rises=%0d hp=%0d simul=%0d miso=0x%02h/%0d wr=%0d rd=%0d err=%0d",
                 rw, addr, data, n, hp, simul, mbits, mcnt, wr_n - wr0, rd_n - rd0, err_n - err0);
    endtask

    initial begin
        logic [7:0] mb;
        int mc, wr0, rd0, err0, n;
        bit rw, simul;
        for (int i = 0; i < 128; i++) begin
            tb_regs[i]   = 8'($urandom);
            model_mem[i] = tb_regs[i];
        end
        rst = 1'b1;
        bus.spi_sck = 1'b0;
        bus.fpga_cs = 1'b1;
        bus.fpga_mosi = 1'b0;
        tick(4);
        chk("reset_state", {bus.busy, bus.reg_wr, bus.reg_rd, bus.frame_err,
                            bus.fpga_miso, bus.reg_addr, bus.reg_wdata}, 32'd0);
        rst = 1'b0;
        tick(6);

        // Directed frames
        run_frame(1'b0, 7'h05, 8'h2A, 16, 8, 1'b0, 8);
        tb_regs[7'h11] = 8'hC3;
        model_mem[7'h11] = 8'hC3;
        run_frame(1'b1, 7'h11, 8'h00, 16, 8, 1'b0, 8);
        run_frame(1'b0, 7'h22, 8'h99, 10, 8, 1'b0, 8);
        run_frame(1'b0, 7'h7F, 8'h55, 20, 8, 1'b0, 8);

        // Reset in the middle of a frame with CS held low
        wr0 = wr_n; rd0 = rd_n; err0 = err_n;
        spi_xfer({1'b0, 7'h44, 8'h66}, 16, 8, 1'b0, 6, 8, mb, mc);
        chk("rst_no_strobe", {wr_n - wr0, rd_n - rd0, err_n - err0}, 32'd0);
        chk("rst_busy_low", busy_n - busy_base, 0);
        $display("frame reset-mid-frame wr=%0d rd=%0d err=%0d busy_cycles=%0d",
                 wr_n - wr0, rd_n - rd0, err_n - err0, busy_n - busy_base);
        run_frame(1'b0, 7'h03, 8'h01, 16, 8, 1'b0, 8);

        // Back-to-back writes with a short CS-high gap
        run_frame(1'b0, 7'h0A, 8'h11, 16, 8, 1'b0, 4);
        run_frame(1'b0, 7'h0B, 8'h22, 16, 8, 1'b0, 4);

        // Final rise coincident with CS rise still completes the frame
        run_frame(1'b0, 7'h2C, 8'hE7, 16, 7, 1'b1, 6);
        run_frame(1'b1, 7'h2C, 8'h00, 16, 7, 1'b1, 6);

        // Randomised frames
        for (int k = 0; k < 30; k++) begin
            rw = 1'($urandom);
            if ($urandom_range(0, 9) < 7) n = $urandom_range(16, 20);
            else n = $urandom_range(1, 15);
            simul = (n == 16) && ($urandom_range(0, 3) == 0);
            run_frame(rw, 7'($urandom), 8'($urandom), n, $urandom_range(6, 9),
                      simul, $urandom_range(4, 10));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
